serial_abs_sub: RTL and testbench
=================================

Name: serial_abs_sub

Overview:
- Parametrised, bit-serial two's-complement subtractor. Returns the unsigned magnitude |a - b| plus a sign flag and a zero flag.
- Processes one bit per clock, LSB first, using a single full-adder cell. The subtract pass computes a + ~b + 1.
- When the subtract pass produces a borrow, a second serial pass two's-complements the result back to a magnitude.
- Used in area-constrained datapaths where a WIDTH-bit parallel subtractor is too costly. Driven by a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend, unsigned; sampled on the accepted start edge.
- b  input  WIDTH  subtrahend, unsigned; sampled on the accepted start edge.
- busy  output  1  high in SUB, NEG and DONE; low in IDLE.
- done  output  1  one-cycle pulse; high while in DONE.
- y  output  WIDTH  |a - b|; valid from done, held until next accepted start or reset.
- neg  output  1  1 when a < b; valid and held with y.
- zero  output  1  1 when a == b; valid and held with y.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, y=0, neg=0, zero=0; internal shift registers, carry and counter cleared.
- Reset has priority over every other event. Asserting rst mid-operation aborts the operation; the next cycle is IDLE with all outputs 0.
- States: IDLE, SUB, NEG, DONE.
- IDLE:
  - start=1 on an edge: latch a into shift register SA and b into SB; carry c=1; cnt=0; go to SUB.
  - start=0: stay in IDLE; y, neg and zero hold their values.
- SUB, one edge per bit, i = cnt:
  - s = SA[0] ^ ~SB[0] ^ c.
  - c <= (SA[0] & ~SB[0]) | (c & (SA[0] ^ ~SB[0])).
  - Result register R shifts right with s entering at the MSB; SA and SB shift right.
  - cnt increments each edge.
  - On the edge where cnt == WIDTH-1, evaluate the carry-out (the c computed on that edge):
    - carry-out = 1 (a >= b): go to DONE.
    - carry-out = 0 (a < b): set neg flag, set c=1, cnt=0, go to NEG.
- NEG, one edge per bit:
  - t = ~R[0] ^ c.
  - c <= ~R[0] & c.
  - R shifts right with t entering at the MSB.
  - On the edge where cnt == WIDTH-1, go to DONE.
- DONE, exactly one cycle:
  - done=1; y=R; neg as determined in SUB; zero=(R==0).
  - Next edge: go to IDLE unconditionally.
  - y, neg and zero then hold in IDLE.
- Latency, with start sampled at edge 0:
  - a >= b: done high after edge WIDTH.
  - a < b: done high after edge 2*WIDTH.
- Throughput: minimum gap between accepted starts is WIDTH+2 cycles (a >= b) or 2*WIDTH+2 cycles (a < b).
- start while busy=1 (including the DONE cycle) is ignored, has no side effect and is not queued. a and b may change freely after the accepted start edge.
- Width rules:
  - The magnitude always fits in WIDTH bits; no overflow output.
  - a == b gives y=0, neg=0, zero=1, and takes the a >= b path.
  - zero=1 implies neg=0.
- y, neg and zero update only on entry to DONE. Their values are undefined to the user before the first done, but are 0 by reset.

Test Plan:
- WIDTH=4, a=9, b=3, start pulse -> done one cycle after edge 4; y=6, neg=0, zero=0; busy high for 5 cycles.
- WIDTH=4, a=3, b=9 -> done after edge 8; y=6, neg=1, zero=0. Also a=0, b=15 -> y=15, neg=1.
- WIDTH=4, a=5, b=5 -> done after edge 4; y=0, neg=0, zero=1. Also a=15, b=0 -> y=15, neg=0.
- WIDTH=8, a=55, b=200 -> y=145, neg=1, done after edge 16. Random sweep of 1000 pairs compared against |a-b| reference model.
- WIDTH=4, start held high for 20 cycles with a=3, b=9 -> accepted only from IDLE; each result y=6, neg=1; done pulses exactly 1 cycle wide; operands changed mid-op do not affect y.
- WIDTH=4, rst asserted during NEG (edge 6) -> next cycle IDLE, busy=0, done=0, y=0, neg=0. New start a=7, b=2 then gives y=5 with correct latency.

Source files
------------

// File: rtl/serial_abs_sub.sv
// Bit-serial |a - b| using one full-adder cell: a subtract pass (a + ~b + 1), then an
// optional negate pass (~R + 1) when the subtract pass ends without a carry-out.
module serial_abs_sub #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             neg,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, r_q, y_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, busy_q, done_q, neg_q, zero_q;

    logic             fa_x, fa_y, fa_sum, fa_cout, last_bit;
    logic [WIDTH-1:0] r_d;

    // The single adder cell is shared: SUB feeds (SA[0], ~SB[0]); NEG feeds (~R[0], 0).
    always_comb begin
        fa_x     = 1'b0;
        fa_y     = 1'b0;
        if (state_q == SUB) begin
            fa_x = sa_q[0];
            fa_y = ~sb_q[0];
        end else begin
            fa_x = ~r_q[0];
            fa_y = 1'b0;
        end
        fa_sum   = fa_x ^ fa_y ^ c_q;
        fa_cout  = (fa_x & fa_y) | (c_q & (fa_x ^ fa_y));
        r_d      = {fa_sum, r_q[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            r_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        c_q     <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    r_q   <= r_d;
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    c_q   <= fa_cout;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        if (fa_cout) begin
                            y_q     <= r_d;
                            neg_q   <= 1'b0;
                            zero_q  <= (r_d == '0);
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // No carry-out means a < b: R holds 2^W - |a-b|, so negate it.
                            c_q     <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= NEG;
                        end
                    end
                end
                NEG: begin
                    r_q   <= r_d;
                    c_q   <= fa_cout;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        y_q     <= r_d;
                        neg_q   <= 1'b1;
                        zero_q  <= (r_d == '0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign y         = y_q;
    assign neg       = neg_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_abs_sub.sv
// Bench for serial_abs_sub: a WIDTH=4 and a WIDTH=8 instance, table vectors, corner
// sequences and a random sweep, results checked through expected-value queues.
module tb_serial_abs_sub;

    logic       clk;
    logic       rst;
    logic       start4, busy4, done4, neg4, zero4;
    logic [3:0] a4, b4, y4;
    logic [1:0] st4;
    logic       start8, busy8, done8, neg8, zero8;
    logic [7:0] a8, b8, y8;
    logic [1:0] st8;

    int total = 0;
    int bad   = 0;

    // Expected record: [9]=neg, [8]=zero, [7:0]=y (zero-extended for the 4-bit unit).
    logic [9:0] exp4_q[$];
    logic [9:0] exp8_q[$];
    logic [9:0] e4, e8;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       neg;
        logic       zero;
        int         lat;
    } vec_t;
    vec_t vecs[8];

    serial_abs_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .y(y4), .neg(neg4), .zero(zero4), .dbg_state(st4)
    );

    serial_abs_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .y(y8), .neg(neg8), .zero(zero8), .dbg_state(st8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done4) begin
            if (exp4_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done4: got 1 expected 0");
            end else begin
                e4 = exp4_q.pop_front();
                check("y4", 32'(y4), 32'(e4[3:0]));
                check("neg4", 32'(neg4), 32'(e4[9]));
                check("zero4", 32'(zero4), 32'(e4[8]));
            end
        end
        if (done8) begin
            if (exp8_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done8: got 1 expected 0");
            end else begin
                e8 = exp8_q.pop_front();
                check("y8", 32'(y8), 32'(e8[7:0]));
                check("neg8", 32'(neg8), 32'(e8[9]));
                check("zero8", 32'(zero8), 32'(e8[8]));
            end
        end
    end

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input int lat,
                       input logic [9:0] exp);
        int cyc;
        int bcnt;
        @(negedge clk);
        a4 = ta;
        b4 = tb;
        start4 = 1'b1;
        exp4_q.push_back(exp);
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom_range(0, 15));
        b4 = 4'($urandom_range(0, 15));
        cyc = 0;
        bcnt = busy4 ? 1 : 0;
        while (!done4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy4) bcnt++;
        end
        check("latency4", 32'(cyc), 32'(lat));
        check("busy_cycles4", 32'(bcnt), 32'(lat + 1));
        @(negedge clk);
        check("after_done4", {30'd0, done4, busy4}, 32'd0);
        check("hold_y4", 32'(y4), 32'(exp[3:0]));
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb);
        int cyc;
        int lat;
        logic [9:0] exp;
        if (ta >= tb) exp = {1'b0, ta == tb, 8'(ta - tb)};
        else          exp = {1'b1, 1'b0, 8'(tb - ta)};
        lat = (ta < tb) ? 16 : 8;
        @(negedge clk);
        a8 = ta;
        b8 = tb;
        start8 = 1'b1;
        exp8_q.push_back(exp);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        cyc = 0;
        while (!done8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("latency8", 32'(cyc), 32'(lat));
        @(negedge clk);
        check("after_done8", {30'd0, done8, busy8}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd9,  4'd3,  4'd6,  1'b0, 1'b0, 4};
        vecs[1] = '{4'd3,  4'd9,  4'd6,  1'b1, 1'b0, 8};
        vecs[2] = '{4'd0,  4'd15, 4'd15, 1'b1, 1'b0, 8};
        vecs[3] = '{4'd5,  4'd5,  4'd0,  1'b0, 1'b1, 4};
        vecs[4] = '{4'd15, 4'd0,  4'd15, 1'b0, 1'b0, 4};
        vecs[5] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b1, 4};
        vecs[6] = '{4'd1,  4'd2,  4'd1,  1'b1, 1'b0, 8};
        vecs[7] = '{4'd8,  4'd7,  4'd1,  1'b0, 1'b0, 4};

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        check("rst_state4", 32'(st4), 32'd0);
        check("rst_outs4", {27'd0, busy4, done4, neg4, zero4, |y4}, 32'd0);
        check("rst_outs8", {27'd0, busy8, done8, neg8, zero8, |y8}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            op4(vecs[i].a, vecs[i].b, vecs[i].lat,
                {vecs[i].neg, vecs[i].zero, 4'd0, vecs[i].y});

        // start held high for 20 edges: only edges 0 and 10 are accepted
        @(negedge clk);
        a4 = 4'd3;
        b4 = 4'd9;
        start4 = 1'b1;
        exp4_q.push_back({1'b1, 1'b0, 8'd6});
        exp4_q.push_back({1'b1, 1'b0, 8'd6});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("held_done_at_edge", 32'(done4), 32'((k == 8 || k == 18) ? 1 : 0));
            if (k == 1) begin
                a4 = 4'd15;
                b4 = 4'd0;
            end
            if (k == 7) begin
                a4 = 4'd3;
                b4 = 4'd9;
            end
        end
        start4 = 1'b0;
        @(negedge clk);
        check("held_queue_empty", 32'(exp4_q.size()), 32'd0);
        check("held_idle", 32'(st4), 32'd0);

        // reset during the negate pass aborts the operation
        @(negedge clk);
        a4 = 4'd3;
        b4 = 4'd9;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (5) @(negedge clk);
        check("in_neg_state", 32'(st4), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", 32'(st4), 32'd0);
        check("abort_outs", {27'd0, busy4, done4, neg4, zero4, |y4}, 32'd0);
        op4(4'd7, 4'd2, 4, {1'b0, 1'b0, 8'd5});

        op8(8'd55, 8'd200);
        op8(8'd255, 8'd0);
        op8(8'd0, 8'd255);
        op8(8'd128, 8'd128);
        for (int i = 0; i < 1000; i++)
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        repeat (3) @(negedge clk);
        check("final_queue4", 32'(exp4_q.size()), 32'd0);
        check("final_queue8", 32'(exp8_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
